// File: rtl/ped_request_ctrl_if.sv
// rtl/ped_request_ctrl_if.sv - pedestrian request controller signal bundle
//
// Groups the button, crossing status and request outputs of ped_request_ctrl.
//   btn_raw       raw pedestrian button, asynchronous, 1 = pressed
//   pause         1 = freeze all counters and the FSM
//   pattern       crossing pattern, 0 = STOP, 1 = WALK
//   second        current countdown value, unsigned
//   change_state  one-cycle request pulse to the phase counter
//   req_led       request-pending lamp
//   busy          1 while the controller is locked out
// master: drives the inputs (environment / bench); slave: the controller.
interface ped_request_ctrl_if;
    logic       btn_raw;
    logic       pause;
    logic       pattern;
    logic [3:0] second;
    logic       change_state;
    logic       req_led;
    logic       busy;

    modport master (
        output btn_raw, pause, pattern, second,
        input  change_state, req_led, busy
    );

    modport slave (
        input  btn_raw, pause, pattern, second,
        output change_state, req_led, busy
    );
endinterface

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian push-button to change_state request controller
//
// Synchronises and debounces the pedestrian button, holds a pending request,
// forwards it as a single change_state pulse while the crossing shows STOP
// with enough countdown left, then locks out further presses for a while.
//
// Ports:
//   clk   in  system clock, rising edge
//   rst   in  asynchronous, active-low reset
//   bus   slave modport of ped_request_ctrl_if
//         (btn_raw, pause, pattern, second in; change_state, req_led, busy out)
//
// Optional feature macro: REQ_ACK_BLINK_EN
//   defined   : req_led blinks with half-period BLINK_CYCLES in PENDING and is
//               steady on in LOCKOUT; BLINK_CYCLES parameter exists.
//   undefined : req_led = (state == PENDING); no blink logic, no BLINK_CYCLES.
module ped_request_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 50_000,
    parameter logic [3:0] MIN_SECOND      = 4'd5,
    parameter int         LOCKOUT_CYCLES  = 25_000_000
`ifdef REQ_ACK_BLINK_EN
    ,
    parameter int         BLINK_CYCLES    = 12_500_000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    ped_request_ctrl_if.slave  bus
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int LO_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LO_W-1:0] LO_MAX = LO_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ISSUE   = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic            sync_ff1;
    logic            btn_sync;
    logic            btn_stable;
    logic            btn_stable_d;
    logic [DB_W-1:0] db_cnt;
    logic [LO_W-1:0] lo_cnt;
    logic            press;

    // Synchroniser runs freely; debounce and edge detection freeze on pause
    // so that a press in progress resumes from its held count afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_ff1     <= 1'b0;
            btn_sync     <= 1'b0;
            btn_stable   <= 1'b0;
            btn_stable_d <= 1'b0;
            db_cnt       <= '0;
        end else begin
            sync_ff1 <= bus.btn_raw;
            btn_sync <= sync_ff1;
            if (!bus.pause) begin
                btn_stable_d <= btn_stable;
                if (btn_sync == btn_stable) begin
                    db_cnt <= '0;
                end else if (db_cnt == DB_MAX) begin
                    // Counter saturates here; it clears once stable catches up.
                    btn_stable <= btn_sync;
                end else begin
                    db_cnt <= db_cnt + DB_W'(1);
                end
            end
        end
    end

    // Held high across a pause because btn_stable_d is frozen too.
    assign press = btn_stable & ~btn_stable_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_cnt <= '0;
        end else if (!bus.pause) begin
            if (state == LOCKOUT) begin
                if (lo_cnt != LO_MAX) begin
                    lo_cnt <= lo_cnt + LO_W'(1);
                end
            end else begin
                lo_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every transition is gated by pause. ISSUE waits in place while paused
    // and pulses only on the cycle it leaves, so the pulse is always single.
    always_comb begin
        next_state       = state;
        bus.change_state = 1'b0;
        bus.busy         = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.pause && press) begin
                    next_state = PENDING;
                end
            end
            PENDING: begin
                if (!bus.pause) begin
                    if (bus.pattern) begin
                        next_state = IDLE;
                    end else if (bus.second > MIN_SECOND) begin
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (!bus.pause) begin
                    bus.change_state = 1'b1;
                    next_state       = LOCKOUT;
                end
            end
            LOCKOUT: begin
                bus.busy = 1'b1;
                if (!bus.pause && (lo_cnt == LO_MAX)) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef REQ_ACK_BLINK_EN
    localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

    logic [BL_W-1:0] bl_cnt;
    logic            blink_led;

    // Restarts on every state change so PENDING always opens with the lamp on.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bl_cnt    <= '0;
            blink_led <= 1'b1;
        end else if (next_state != state) begin
            bl_cnt    <= '0;
            blink_led <= 1'b1;
        end else if (!bus.pause && (state == PENDING)) begin
            if (bl_cnt == BL_MAX) begin
                bl_cnt    <= '0;
                blink_led <= ~blink_led;
            end else begin
                bl_cnt <= bl_cnt + BL_W'(1);
            end
        end
    end

    assign bus.req_led = ((state == PENDING) && blink_led) || (state == LOCKOUT);
`else
    assign bus.req_led = (state == PENDING);
`endif

endmodule
